// File: rtl/frame_sequencer.sv
// APU frame counter: quarter/half-frame strobes, $4017 mode/restart handling, frame IRQ.
// Optional IRQ logic is enabled by defining FRAME_SEQUENCER_IRQ_EN.
module frame_sequencer #(
    parameter int CNT_W       = 16,
    parameter int STEP1       = 7457,
    parameter int STEP2       = 14913,
    parameter int STEP3       = 22371,
    parameter int STEP4       = 29829,
    parameter int STEP5       = 37281,
    parameter int WRITE_DELAY = 3
) (
    input  logic       clk,
    input  logic       iReset,
    input  logic       iWrite_4017,
    input  logic [7:0] iData,
    input  logic       iRead_4015,
    output logic       oQuarter_clk,
    output logic       oHalf_clk,
    output logic       oFrame_irq,
    output logic       oMode
);

    localparam logic [CNT_W-1:0] L_STEP1   = CNT_W'(STEP1);
    localparam logic [CNT_W-1:0] L_STEP2   = CNT_W'(STEP2);
    localparam logic [CNT_W-1:0] L_STEP3   = CNT_W'(STEP3);
    localparam logic [CNT_W-1:0] L_STEP4   = CNT_W'(STEP4);
    localparam logic [CNT_W-1:0] L_STEP4M1 = CNT_W'(STEP4 - 1);
    localparam logic [CNT_W-1:0] L_STEP5   = CNT_W'(STEP5);
    localparam logic [2:0]       L_DELAY   = 3'(WRITE_DELAY - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_mode;
    logic             r_pending;
    logic [2:0]       r_delay;
    logic             r_quarter;
    logic             r_half;

    logic [CNT_W-1:0] w_last;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_restart;
    logic             w_quarter_nxt;
    logic             w_half_nxt;
    logic             w_unused;

    // A write on the same edge as an expiring delay re-arms rather than restarts.
    always_comb begin
        w_restart     = r_pending && (r_delay == 3'd0) && !iWrite_4017;
        w_last        = r_mode ? L_STEP5 : L_STEP4;
        w_cnt_nxt     = r_cnt + 1'b1;
        w_quarter_nxt = 1'b0;
        w_half_nxt    = 1'b0;
        if (w_restart) begin
            w_cnt_nxt     = '0;
            w_quarter_nxt = r_mode;
            w_half_nxt    = r_mode;
        end else begin
            if (r_cnt == w_last)
                w_cnt_nxt = '0;
            w_quarter_nxt = (r_cnt == L_STEP1) || (r_cnt == L_STEP2) ||
                            (r_cnt == L_STEP3) || (r_cnt == w_last);
            w_half_nxt    = (r_cnt == L_STEP2) || (r_cnt == w_last);
        end
    end

    always_ff @(posedge clk) begin
        if (iReset) begin
            r_cnt     <= '0;
            r_mode    <= 1'b0;
            r_pending <= 1'b0;
            r_delay   <= 3'd0;
            r_quarter <= 1'b0;
            r_half    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_quarter <= w_quarter_nxt;
            r_half    <= w_half_nxt;
            if (iWrite_4017) begin
                r_mode    <= iData[7];
                r_pending <= 1'b1;
                r_delay   <= L_DELAY;
            end else if (w_restart) begin
                r_pending <= 1'b0;
            end else if (r_pending) begin
                r_delay   <= r_delay - 1'b1;
            end
        end
    end

    assign oQuarter_clk = r_quarter;
    assign oHalf_clk    = r_half;
    assign oMode        = r_mode;

`ifdef FRAME_SEQUENCER_IRQ_EN
    logic r_irq;
    logic r_inhibit;
    logic w_irq_set;

    assign w_irq_set = !r_mode && !r_inhibit &&
                       ((r_cnt == L_STEP4M1) || (r_cnt == L_STEP4));

    // Inhibiting write clears outright; otherwise a set beats a same-edge read clear.
    always_ff @(posedge clk) begin
        if (iReset) begin
            r_irq     <= 1'b0;
            r_inhibit <= 1'b0;
        end else begin
            if (iWrite_4017)
                r_inhibit <= iData[6];
            if (iWrite_4017 && iData[6])
                r_irq <= 1'b0;
            else if (w_irq_set)
                r_irq <= 1'b1;
            else if (iRead_4015)
                r_irq <= 1'b0;
        end
    end

    assign oFrame_irq = r_irq;
    assign w_unused   = &{1'b0, iData[5:0]};
`else
    assign oFrame_irq = 1'b0;
    assign w_unused   = &{1'b0, iData[6:0], iRead_4015};
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer using shortened step values to keep runs brief.
module tb_frame_sequencer;

    localparam int S1 = 745;
    localparam int S2 = 1491;
    localparam int S3 = 2237;
    localparam int S4 = 2982;
    localparam int S5 = 3728;

`ifdef FRAME_SEQUENCER_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       iReset = 1'b1;
    logic       iWrite_4017 = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       iRead_4015 = 1'b0;
    logic       oQuarter_clk;
    logic       oHalf_clk;
    logic       oFrame_irq;
    logic       oMode;

    frame_sequencer #(
        .CNT_W(16), .STEP1(S1), .STEP2(S2), .STEP3(S3),
        .STEP4(S4), .STEP5(S5), .WRITE_DELAY(3)
    ) dut (
        .clk         (clk),
        .iReset      (iReset),
        .iWrite_4017 (iWrite_4017),
        .iData       (iData),
        .iRead_4015  (iRead_4015),
        .oQuarter_clk(oQuarter_clk),
        .oHalf_clk   (oHalf_clk),
        .oFrame_irq  (oFrame_irq),
        .oMode       (oMode)
    );

    always #5 clk = ~clk;

    typedef struct {
        int edge_n;
        bit rd;
        bit q;
        bit h;
        bit irq;
    } vec_t;

    vec_t vecs[12];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_cnt = 0;
    int   pulses;

    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_irq(input bit v);
        return IRQ_EN ? v : 1'b0;
    endfunction

    task automatic chk_qh(input string name, input bit q, input bit h);
        chk({name, "_q"}, oQuarter_clk, q);
        chk({name, "_h"}, oHalf_clk, h);
    endtask

    initial begin
        // Edge n after reset release samples cnt == n-1.
        vecs[0]  = '{S1,     1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{S1 + 1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{S1 + 2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{S2 + 1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{S2 + 2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{S3 + 1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{S4 - 1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{S4,     1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{S4 + 1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{S4 + 2, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{S4 + 10, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{S4 + 11, 1'b1, 1'b0, 1'b0, 1'b0};

        iReset = 1'b1;
        ticks(2);
        chk_qh("reset", 1'b0, 1'b0);
        chk("reset_irq", oFrame_irq, 1'b0);
        chk("reset_mode", oMode, 1'b0);
        iReset = 1'b0;
        edge_cnt = 0;

        for (int i = 0; i < 12; i++) begin
            while (edge_cnt < vecs[i].edge_n - 1) tick();
            iRead_4015 = vecs[i].rd;
            tick();
            iRead_4015 = 1'b0;
            chk_qh($sformatf("vec%0d", i), vecs[i].q, vecs[i].h);
            chk($sformatf("vec%0d_irq", i), oFrame_irq, exp_irq(vecs[i].irq));
            chk($sformatf("vec%0d_mode", i), oMode, 1'b0);
        end

        // cnt == 10 here; let irq set again, then clear it with an inhibiting write.
        ticks(S4 - 10);
        chk("irq_reset_again", oFrame_irq, exp_irq(1'b1));
        ticks(2);
        iWrite_4017 = 1'b1; iData = 8'h40;
        tick();
        iWrite_4017 = 1'b0; iData = 8'h00;
        chk("wr40_irq_clr", oFrame_irq, 1'b0);
        chk("wr40_mode", oMode, 1'b0);
        ticks(2);
        tick();
        chk_qh("wr40_restart", 1'b0, 1'b0);
        ticks(S4);
        chk("inh_irq_s4m1", oFrame_irq, 1'b0);
        tick();
        chk_qh("inh_wrap", 1'b1, 1'b1);
        chk("inh_irq_wrap", oFrame_irq, 1'b0);

        // 5-step switch at cnt 100.
        ticks(100);
        iWrite_4017 = 1'b1; iData = 8'h80;
        tick();
        iWrite_4017 = 1'b0; iData = 8'h00;
        chk("wr80_mode", oMode, 1'b1);
        ticks(2);
        chk_qh("wr80_wait", 1'b0, 1'b0);
        tick();
        chk_qh("wr80_imm", 1'b1, 1'b1);
        tick();
        chk_qh("wr80_imm_end", 1'b0, 1'b0);
        ticks(S1 - 1);
        chk_qh("m1_pre_s1", 1'b0, 1'b0);
        tick();
        chk_qh("m1_s1", 1'b1, 1'b0);
        ticks(S2 - S1 - 1);
        tick();
        chk_qh("m1_s2", 1'b1, 1'b1);
        ticks(S4 - S2 - 1);
        tick();
        chk_qh("m1_s4_none", 1'b0, 1'b0);
        chk("m1_s4_irq", oFrame_irq, 1'b0);
        ticks(S5 - S4 - 1);
        tick();
        chk_qh("m1_s5", 1'b1, 1'b1);
        chk("m1_s5_irq", oFrame_irq, 1'b0);
        ticks(S1);
        tick();
        chk_qh("m1_period", 1'b1, 1'b0);

        // Two writes two cycles apart: only the second one's restart happens.
        iWrite_4017 = 1'b1; iData = 8'h00;
        tick();
        iWrite_4017 = 1'b0;
        chk("dbl_mode0", oMode, 1'b0);
        tick();
        iWrite_4017 = 1'b1; iData = 8'h80;
        tick();
        iWrite_4017 = 1'b0; iData = 8'h00;
        chk("dbl_mode1", oMode, 1'b1);
        ticks(2);
        chk_qh("dbl_wait", 1'b0, 1'b0);
        tick();
        chk_qh("dbl_imm", 1'b1, 1'b1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (oQuarter_clk || oHalf_clk) pulses++;
        end
        chk_int("dbl_extra_pulses", pulses, 0);

        // Mid-sequence reset.
        iReset = 1'b1;
        tick();
        chk_qh("midrst", 1'b0, 1'b0);
        chk("midrst_mode", oMode, 1'b0);
        chk("midrst_irq", oFrame_irq, 1'b0);
        iReset = 1'b0;
        ticks(S1);
        chk_qh("midrst_pre_s1", 1'b0, 1'b0);
        tick();
        chk_qh("midrst_s1", 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
